// File: rtl/seq_alu.sv
// Registered funct3 ALU with start/busy/done handshake; shifts run 1 bit/cycle
// unless SEQ_ALU_FAST_SHIFT_EN is defined, which selects a single-cycle barrel shifter.
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cmp
);

  localparam int SHW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] W_MAX = WIDTH'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SHIFT, S_DONE} state_t;

  state_t           r_state;
  logic [2:0]       r_op;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_cmp;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_is_shift;
  logic             w_go_shift;
  logic [SHW-1:0]   w_n;
  logic [WIDTH-1:0] w_res;
  logic             w_cmp;

  assign w_accept   = start && !r_busy;
  assign w_is_shift = funct3[2] && (funct3[1:0] != 2'd0);
  // Amounts beyond the width saturate so the counter never needs more than SHW bits.
  assign w_n        = (b >= W_MAX) ? SHW'(WIDTH) : b[SHW-1:0];

`ifdef SEQ_ALU_FAST_SHIFT_EN
  assign w_go_shift = 1'b0;
`else
  assign w_go_shift = w_is_shift && (w_n != '0);
`endif

  always_comb begin
    w_res = a;
    unique case (funct3)
      3'd0: w_res = a + b;
      3'd1: w_res = a - b;
      3'd2: w_res = a ^ b;
      3'd3: w_res = a | b;
      3'd4: w_res = a & b;
`ifdef SEQ_ALU_FAST_SHIFT_EN
      3'd5: w_res = a << w_n;
      3'd6: w_res = a >> w_n;
      3'd7: w_res = WIDTH'($signed(a) >>> w_n);
`else
      // Iterative shifts start from a; the SHIFT state walks it n times.
      default: w_res = a;
`endif
    endcase
  end

  always_comb begin
    w_cmp = 1'b0;
    unique case (funct3[1:0])
      2'd0: w_cmp = (a == b);
      2'd1: w_cmp = (a != b);
      2'd2: w_cmp = ($signed(a) <  $signed(b));
      2'd3: w_cmp = ($signed(a) >= $signed(b));
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cmp    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_op     <= funct3;
            r_result <= w_res;
            r_cmp    <= w_cmp;
            r_busy   <= 1'b1;
            if (w_go_shift) begin
              r_cnt   <= w_n;
              r_state <= S_SHIFT;
            end else begin
              r_state <= S_EXEC;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_EXEC: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_SHIFT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
            unique case (r_op[1:0])
              2'd1:    r_result <= {r_result[WIDTH-2:0], 1'b0};
              2'd2:    r_result <= {1'b0, r_result[WIDTH-1:1]};
              default: r_result <= {r_result[WIDTH-1], r_result[WIDTH-1:1]};
            endcase
          end else begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign cmp    = r_cmp;

endmodule

// File: tb/tb_seq_alu.sv
// Directed table-driven bench for seq_alu (WIDTH=16), plus reset and handshake sequences.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [15:0] a, b;
  logic        busy, done, cmp;
  logic [15:0] result;

  int checks   = 0;
  int failures = 0;

  seq_alu #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cmp(cmp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        cmp;
    int          lat;   // cycles from accept edge to done, default (iterative) build
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Issue one op from idle; returns observed latency and whether busy stayed high until done.
  task automatic run_op(input logic [2:0] f, input logic [15:0] va, input logic [15:0] vb,
                        output int lat, output logic busy_ok);
    @(negedge clk);
    funct3 = f; a = va; b = vb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, exp_lat, n;
    logic bok;
    bit saw_done;

    vt[0]  = '{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1};
    vt[1]  = '{3'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1};
    vt[2]  = '{3'd2, 16'hFFFD, 16'h0002, 16'hFFFF, 1'b1, 1};
    vt[3]  = '{3'd3, 16'hFFFD, 16'h0002, 16'hFFFF, 1'b0, 1};
    vt[4]  = '{3'd0, 16'h0005, 16'h0005, 16'h000A, 1'b1, 1};
    vt[5]  = '{3'd1, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1};
    vt[6]  = '{3'd4, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1};
    vt[7]  = '{3'd7, 16'h8001, 16'h0004, 16'hF800, 1'b0, 5};
    vt[8]  = '{3'd6, 16'h8001, 16'd20,   16'h0000, 1'b1, 17};
    vt[9]  = '{3'd5, 16'h8001, 16'h0000, 16'h8001, 1'b1, 1};
    vt[10] = '{3'd5, 16'h0001, 16'd15,   16'h8000, 1'b1, 16};
    vt[11] = '{3'd7, 16'h8000, 16'd16,   16'hFFFF, 1'b0, 17};
    vt[12] = '{3'd6, 16'h8000, 16'h0001, 16'h4000, 1'b1, 2};
    vt[13] = '{3'd5, 16'h1234, 16'hFFFF, 16'h0000, 1'b1, 17};

    rst_n = 1'b0; start = 1'b0; funct3 = 3'd0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_cmp", {31'd0, cmp}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    foreach (vt[i]) begin
      exp_lat = vt[i].lat;
`ifdef SEQ_ALU_FAST_SHIFT_EN
      exp_lat = 1;
`endif
      run_op(vt[i].f, vt[i].a, vt[i].b, lat, bok);
      chk($sformatf("v%0d_latency", i), lat, exp_lat);
      chk($sformatf("v%0d_result", i), {16'd0, result}, {16'd0, vt[i].res});
      chk($sformatf("v%0d_cmp", i), {31'd0, cmp}, {31'd0, vt[i].cmp});
      chk($sformatf("v%0d_busy_held", i), {31'd0, bok}, 32'd1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
    end

    // Reset in the middle of a long shift aborts it immediately.
    @(negedge clk);
    funct3 = 3'd7; a = 16'h8001; b = 16'd10; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_result", {16'd0, result}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    chk("midrst_no_done", {31'd0, saw_done}, 32'd0);

    // start held high across three ops: each accepted in the previous DONE cycle.
    @(negedge clk);
    funct3 = 3'd0; a = 16'd1; b = 16'd2; start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("b2b0_done", {31'd0, done}, 32'd1);
    chk("b2b0_result", {16'd0, result}, 32'd3);
    funct3 = 3'd1; a = 16'd10; b = 16'd3;
    @(posedge clk); #1;
    chk("b2b1_accept_busy", {31'd0, busy}, 32'd1);
    chk("b2b1_done_low", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    chk("b2b1_done", {31'd0, done}, 32'd1);
    chk("b2b1_result", {16'd0, result}, 32'd7);
    funct3 = 3'd2; a = 16'h00FF; b = 16'h0F0F;
    @(posedge clk); #1;
    chk("b2b2_accept_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk("b2b2_done", {31'd0, done}, 32'd1);
    chk("b2b2_result", {16'd0, result}, 32'h0FF0);
    start = 1'b0;
    @(posedge clk); #1;
    chk("b2b_end_done", {31'd0, done}, 32'd0);
    chk("b2b_end_busy", {31'd0, busy}, 32'd0);

    // start pulsed while busy is dropped, not queued.
    @(negedge clk);
    funct3 = 3'd0; a = 16'd2; b = 16'd3; start = 1'b1;
    @(posedge clk); #1;
    funct3 = 3'd1; a = 16'd100; b = 16'd1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ign_done", {31'd0, done}, 32'd1);
    chk("ign_result", {16'd0, result}, 32'd5);
    @(posedge clk); #1;
    chk("ign_busy_after", {31'd0, busy}, 32'd0);
    chk("ign_done_after", {31'd0, done}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("ign_result_held", {16'd0, result}, 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
